irq_ctrl: RTL and testbench



---
 rtl/irq_pkg.sv | 14 +
 rtl/irq_arbiter.sv | 54 +++++
 rtl/irq_ctrl.sv | 105 ++++++++++
 tb/tb_irq_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and constants for the interrupt controller
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    FIN,
    WAIT_DROP
  } irq_state_t;

  localparam int MCAUSE_INT_BIT = 31;
  localparam int IRQ_NUM_DEF    = 32;

endpackage

// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - combinational source selector over the eligible vector
// IRQ_CTRL_RR_EN: round-robin from last_id+1; undefined: lowest eligible index wins.
module irq_arbiter #(
  parameter int IRQ_NUM = 32,
  parameter int ID_W    = $clog2(IRQ_NUM)
) (
  input  logic [IRQ_NUM-1:0] elig_i,
`ifdef IRQ_CTRL_RR_EN
  input  logic [ID_W-1:0]    last_id_i,
`endif
  output logic               valid_o,
  output logic [ID_W-1:0]    id_o
);

`ifdef IRQ_CTRL_RR_EN
  logic [ID_W-1:0] start;
  logic [ID_W-1:0] idx;
  logic            found;
  int              pos;

  // Wrap is explicit so non-power-of-two IRQ_NUM never indexes past the top line.
  always_comb begin
    start   = (int'(last_id_i) == IRQ_NUM - 1) ? '0 : last_id_i + 1'b1;
    found   = 1'b0;
    id_o    = '0;
    idx     = '0;
    pos     = 0;
    for (int k = 0; k < IRQ_NUM; k++) begin
      pos = int'(start) + k;
      if (pos >= IRQ_NUM) begin
        pos = pos - IRQ_NUM;
      end
      idx = ID_W'(pos);
      if (!found && elig_i[idx]) begin
        found = 1'b1;
        id_o  = idx;
      end
    end
    valid_o = found;
  end
`else
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    for (int k = IRQ_NUM - 1; k >= 0; k--) begin
      if (elig_i[k]) begin
        valid_o = 1'b1;
        id_o    = ID_W'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - interrupt controller: grant FSM, cause latch, completion pulse
// IRQ_CTRL_RR_EN enables round-robin arbitration (fixed priority when undefined).
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int IRQ_NUM = IRQ_NUM_DEF,
  parameter int ID_W    = $clog2(IRQ_NUM)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [IRQ_NUM-1:0] int_req_i,
  output logic [IRQ_NUM-1:0] int_fin_o,
  input  logic [IRQ_NUM-1:0] mie_i,
  output logic               irq_o,
  output logic [31:0]        mcause_o,
  input  logic               irq_ret_i
);

  irq_state_t      state_q, state_d;
  logic [ID_W-1:0] cur_id_q, cur_id_d;
  logic [31:0]     mcause_q, mcause_d;
  logic [IRQ_NUM-1:0] elig;
  logic            arb_valid;
  logic [ID_W-1:0] arb_id;

  assign elig = int_req_i & mie_i;

`ifdef IRQ_CTRL_RR_EN
  logic [ID_W-1:0] last_id_q, last_id_d;

  irq_arbiter #(.IRQ_NUM(IRQ_NUM), .ID_W(ID_W)) u_arb (
    .elig_i    (elig),
    .last_id_i (last_id_q),
    .valid_o   (arb_valid),
    .id_o      (arb_id)
  );

  assign last_id_d = (state_q == FIN) ? cur_id_q : last_id_q;

  // Reset pointer sits on the top line so the first search begins at index 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_id_q <= ID_W'(IRQ_NUM - 1);
    end else begin
      last_id_q <= last_id_d;
    end
  end
`else
  irq_arbiter #(.IRQ_NUM(IRQ_NUM), .ID_W(ID_W)) u_arb (
    .elig_i  (elig),
    .valid_o (arb_valid),
    .id_o    (arb_id)
  );
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (arb_valid) state_d = PENDING;
      PENDING:   if (irq_ret_i) state_d = FIN;
      FIN:       state_d = WAIT_DROP;
      WAIT_DROP: if (!int_req_i[cur_id_q]) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Grant latches: only an IDLE-state grant updates the id and cause.
  always_comb begin
    cur_id_d = cur_id_q;
    mcause_d = mcause_q;
    if (state_q == IDLE && arb_valid) begin
      cur_id_d                 = arb_id;
      mcause_d                 = 32'(arb_id);
      mcause_d[MCAUSE_INT_BIT] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_id_q <= '0;
      mcause_q <= '0;
    end else begin
      cur_id_q <= cur_id_d;
      mcause_q <= mcause_d;
    end
  end

  always_comb begin
    irq_o     = (state_q == PENDING);
    int_fin_o = '0;
    if (state_q == FIN) begin
      int_fin_o[cur_id_q] = 1'b1;
    end
    mcause_o  = mcause_q;
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - self-checking bench for irq_ctrl against a behavioural model
module tb_irq_ctrl;

  localparam int N  = 32;
  localparam int IW = 5;
  localparam logic [31:0] INT_BIT = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  mie = '0;
  logic          ret = 1'b0;
  logic [N-1:0]  fin;
  logic          irq;
  logic [31:0]   mcause;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.IRQ_NUM(N), .ID_W(IW)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .int_req_i (req),
    .int_fin_o (fin),
    .mie_i     (mie),
    .irq_o     (irq),
    .mcause_o  (mcause),
    .irq_ret_i (ret)
  );

  // Behavioural model: a grant is outstanding until mret, then one completion
  // cycle, then the serviced line must be seen low before the next grant.
  bit          m_busy = 1'b0;
  bit          m_fin_now = 1'b0;
  bit          m_wait = 1'b0;
  int          m_id = 0;
  int          m_ptr = N - 1;
  logic [31:0] m_mcause = '0;

  function automatic int pick(input logic [N-1:0] e, input int ptr);
`ifdef IRQ_CTRL_RR_EN
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (e[idx]) return idx;
    end
`else
    for (int k = 0; k < N; k++) begin
      if (e[k]) return k;
    end
`endif
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_fin_now = 0; m_wait = 0;
      m_id = 0; m_ptr = N - 1; m_mcause = '0;
    end else if (m_fin_now) begin
      m_fin_now = 0;
      m_ptr     = m_id;
      m_wait    = 1;
    end else if (m_busy) begin
      if (ret) begin
        m_busy    = 0;
        m_fin_now = 1;
      end
    end else if (m_wait) begin
      if (!req[m_id]) m_wait = 0;
    end else if ((req & mie) != '0) begin
      m_id     = pick(req & mie, m_ptr);
      m_busy   = 1;
      m_mcause = INT_BIT | 32'(m_id);
    end
  end

  function automatic logic [N-1:0] m_fin_vec();
    logic [N-1:0] v;
    v = '0;
    if (m_fin_now) v[m_id] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cmp_irq", 32'(irq), 32'(m_busy));
    check("cmp_fin", fin, m_fin_vec());
    check("cmp_mcause", mcause, m_mcause);
  end

  task automatic wait_irq(input string name);
    int k;
    k = 0;
    while (!m_busy && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!m_busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: no grant in 60 cycles, irq=%0b required 1", name, irq);
    end
  endtask

  task automatic serve(input int exp_id, input bit reraise, input string name);
    wait_irq(name);
    check({name, "_mcause"}, mcause, INT_BIT | 32'(exp_id));
    check({name, "_model"}, m_mcause, INT_BIT | 32'(exp_id));
    ret = 1'b1;
    @(negedge clk);
    ret = 1'b0;
    check({name, "_fin"}, fin, 32'(1) << exp_id);
    check({name, "_irq_off"}, 32'(irq), 32'd0);
    req[exp_id] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (reraise) req[exp_id] = 1'b1;
  endtask

`ifdef IRQ_CTRL_RR_EN
  int rr_exp[5]   = '{0, 1, 0, 1, 0};
  int wrap_exp[3] = '{0, 31, 0};
`else
  int rr_exp[5]   = '{0, 0, 0, 0, 1};
  int wrap_exp[3] = '{0, 0, 31};
`endif
  bit rr_re[5]   = '{1, 1, 1, 0, 0};
  bit wrap_re[3] = '{1, 0, 0};
  int rel[N];

  initial begin
    repeat (2) @(negedge clk);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_fin", fin, 32'd0);
    check("rst_mcause", mcause, 32'd0);
    rst_n = 1'b1;

    // single source
    @(negedge clk);
    mie = 32'h1;
    req = 32'h1;
    @(negedge clk);
    check("single_irq", 32'(irq), 32'd1);
    check("single_mcause", mcause, 32'h8000_0000);
    serve(0, 0, "single");

    // masked source
    mie = '0;
    req = 32'h4;
    repeat (20) begin
      @(negedge clk);
      check("masked_irq", 32'(irq), 32'd0);
    end
    mie = 32'h4;
    @(negedge clk);
    check("unmask_irq", 32'(irq), 32'd1);
    check("unmask_mcause", mcause, 32'h8000_0002);
    serve(2, 0, "unmask");

    // arbitration between two held lines
    mie = '1;
    req = 32'h3;
    for (int i = 0; i < 5; i++) serve(rr_exp[i], rr_re[i], "rr");

    // pointer parked at 31, then both ends requesting
    req = 32'h8000_0000;
    serve(31, 0, "park");
    req = 32'h8000_0001;
    for (int i = 0; i < 3; i++) serve(wrap_exp[i], wrap_re[i], "wrap");

    // stale level held after completion
    req = 32'h20;
    wait_irq("stale");
    check("stale_mcause", mcause, 32'h8000_0005);
    ret = 1'b1;
    @(negedge clk);
    ret = 1'b0;
    check("stale_fin", fin, 32'h20);
    repeat (10) begin
      @(negedge clk);
      check("stale_irq", 32'(irq), 32'd0);
      check("stale_fin0", fin, 32'd0);
    end
    req[5] = 1'b0;
    @(negedge clk);
    req[5] = 1'b1;
    @(negedge clk);
    check("regrant_irq", 32'(irq), 32'd1);
    check("regrant_mcause", mcause, 32'h8000_0005);
    serve(5, 0, "regrant");

    // reset while pending
    req = 32'h80;
    wait_irq("rstmid");
    check("rstmid_irq", 32'(irq), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_irq0", 32'(irq), 32'd0);
    check("rstmid_fin0", fin, 32'd0);
    check("rstmid_mcause0", mcause, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_regrant", mcause, 32'h8000_0007);
    serve(7, 0, "rstmid");

    // randomized traffic
    for (int i = 0; i < N; i++) rel[i] = -1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c % 50 == 0) mie = $urandom() | $urandom();
      ret = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      for (int i = 0; i < N; i++) begin
        if (m_fin_now && m_id == i) begin
          rel[i] = $urandom_range(0, 3);
        end else if (rel[i] > 0) begin
          rel[i]--;
        end else if (rel[i] == 0) begin
          req[i] = 1'b0;
          rel[i] = -1;
        end else if (!req[i] && $urandom_range(0, 30) == 0) begin
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(0, 400) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    ret = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
